// File: rtl/mix_columns_engine_if.sv
// rtl/mix_columns_engine_if.sv - state-in / result-out handshake bundle for mix_columns_engine
interface mix_columns_engine_if #(
  parameter int COLS = 4
);
  logic                in_valid;
  logic                in_ready;
  logic                in_inverse;
  logic [32*COLS-1:0]  in_state;
  logic                out_valid;
  logic                out_ready;
  logic [32*COLS-1:0]  out_state;

  modport master (
    output in_valid, in_inverse, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_inverse, in_state, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/mix_columns_engine.sv
// rtl/mix_columns_engine.sv - iterative AES MixColumns/InvMixColumns over COLS columns, LANES per cycle
module mix_columns_engine #(
  parameter int COLS  = 4,
  parameter int LANES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  mix_columns_engine_if.slave bus,
  output logic               busy
);
  localparam int W  = 32 * COLS;
  localparam int CW = $clog2(COLS) + 1;

  generate
    if (LANES < 1 || (COLS % ((LANES < 1) ? 1 : LANES)) != 0) begin : g_bad_cfg
      $error("mix_columns_engine: LANES must be >= 1 and divide COLS");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    work, work_nxt;
  logic            mode, mode_nxt;
  logic [CW-1:0]   col_idx, col_idx_nxt;
  logic [31:0]     lane_in  [LANES];
  logic [31:0]     lane_out [LANES];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Both matrices share the x2/x4/x8 chain; the mode bit only selects the final XOR terms.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] s  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] fwd_b, inv_b;
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      s[i]  = col[31-8*i -: 8];
      x2[i] = xtime(s[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int r = 0; r < 4; r++) begin
      fwd_b = x2[r] ^ (x2[(r+1)%4] ^ s[(r+1)%4]) ^ s[(r+2)%4] ^ s[(r+3)%4];
      inv_b = (x8[r] ^ x4[r] ^ x2[r])
            ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ s[(r+1)%4])
            ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ s[(r+2)%4])
            ^ (x8[(r+3)%4] ^ s[(r+3)%4]);
      res[31-8*r -: 8] = inv ? inv_b : fwd_b;
    end
    return res;
  endfunction

  // Lane l works on column col_idx+l; the selects use constant slices only.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = '0;
      for (int c = 0; c < COLS; c++) begin
        if (col_idx + CW'(l) == CW'(c)) begin
          lane_in[l] = work[32*(COLS-1-c) +: 32];
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign lane_out[g] = mix_col(lane_in[g], mode);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      work    <= '0;
      mode    <= 1'b0;
      col_idx <= '0;
    end else begin
      state   <= state_nxt;
      work    <= work_nxt;
      mode    <= mode_nxt;
      col_idx <= col_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    work_nxt    = work;
    mode_nxt    = mode;
    col_idx_nxt = col_idx;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          work_nxt    = bus.in_state;
          mode_nxt    = bus.in_inverse;
          col_idx_nxt = '0;
          state_nxt   = CALC;
        end
      end
      CALC: begin
        for (int c = 0; c < COLS; c++) begin
          for (int l = 0; l < LANES; l++) begin
            if (col_idx + CW'(l) == CW'(c)) begin
              work_nxt[32*(COLS-1-c) +: 32] = lane_out[l];
            end
          end
        end
        col_idx_nxt = col_idx + CW'(LANES);
        if (col_idx + CW'(LANES) == CW'(COLS)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_state = work;
  assign busy          = (state == CALC);

endmodule
